// File: rtl/mac_array_sched.sv
// mac_array_sched: job sequencer for an N x N minifloat systolic MAC array (optional MAC_ARRAY_SCHED_PERF_EN adds job_cnt/busy_cnt)
module mac_array_sched #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int PE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            acc_clr,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [N*DW-1:0] a_rd_data,
  input  logic [N*DW-1:0] b_rd_data,
  output logic [N*DW-1:0] row_feed,
  output logic [N*DW-1:0] col_feed,
  output logic            res_capture
`ifdef MAC_ARRAY_SCHED_PERF_EN
  ,
  output logic [15:0]     job_cnt,
  output logic [31:0]     busy_cnt
`endif
);
  localparam int DRAIN_LEN = N + PE_LAT * N;
  localparam int CW = $clog2(DRAIN_LEN + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic vld;
  logic kill;
  assign kill = abort && busy;
  // job sequencing: clear, fetch N inner indices, drain the array, then strobe completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      acc_clr     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      res_capture <= 1'b0;
      cnt         <= '0;
    end else if (kill) begin
      state   <= IDLE;
      busy    <= 1'b0;
      acc_clr <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start && !abort) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          acc_clr <= 1'b1;
        end
        CLEAR: begin
          state   <= FETCH;
          acc_clr <= 1'b0;
          rd_en   <= 1'b1;
        end
        FETCH: if (rd_addr == AW'(N - 1)) begin
          state   <= DRAIN;
          rd_en   <= 1'b0;
          rd_addr <= '0;
          cnt     <= CW'(DRAIN_LEN - 1);
        end else rd_addr <= rd_addr + 1'b1;
        DRAIN: if (cnt == '0) begin
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          res_capture <= 1'b1;
        end else cnt <= cnt - 1'b1;
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          res_capture <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // read data is valid the cycle after the read was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= 1'b0;
    else vld <= rd_en && !kill;
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_z
      assign row_feed[0+:DW] = vld ? a_rd_data[0+:DW] : '0;
      assign col_feed[0+:DW] = vld ? b_rd_data[0+:DW] : '0;
    end else begin : g_d
      logic [i*DW-1:0]     as, bs;
      logic [i-1:0]        v;
      logic [(i+1)*DW-1:0] an, bn;
      logic [i:0]          vn;
      assign an = {as, a_rd_data[i*DW+:DW]};
      assign bn = {bs, b_rd_data[i*DW+:DW]};
      assign vn = {v, vld};
      // lane i skew: i-deep shift of data and its valid flag, flushed on abort
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {as, bs, v} <= '0;
        else if (kill) {as, bs, v} <= '0;
        else begin
          as <= an[i*DW-1:0];
          bs <= bn[i*DW-1:0];
          v  <= vn[i-1:0];
        end
      end
      assign row_feed[i*DW+:DW] = vn[i] ? an[(i+1)*DW-1-:DW] : '0;
      assign col_feed[i*DW+:DW] = vn[i] ? bn[(i+1)*DW-1-:DW] : '0;
    end
  end
`ifdef MAC_ARRAY_SCHED_PERF_EN
  // completed-job counter wraps, busy-cycle counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt  <= '0;
      busy_cnt <= '0;
    end else begin
      if (done) job_cnt <= job_cnt + 1'b1;
      if (busy && !(&busy_cnt)) busy_cnt <= busy_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_array_sched.sv
// tb_mac_array_sched: scoreboard bench with operand buffer and minifloat PE array model
module tb_mac_array_sched;
  localparam int N = 4, DW = 8, AW = 3, PE_LAT = 2;
  localparam int DRAIN_LEN = N + PE_LAT * N;
  localparam int JOB = 2 + N + DRAIN_LEN;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic busy, done, acc_clr, rd_en, res_capture;
  logic [AW-1:0] rd_addr;
  logic [N*DW-1:0] a_rd_data = '0, b_rd_data = '0, row_feed, col_feed;
  mac_array_sched #(.N(N), .DW(DW), .AW(AW), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .acc_clr(acc_clr), .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data),
    .b_rd_data(b_rd_data), .row_feed(row_feed), .col_feed(col_feed), .res_capture(res_capture)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];
  logic [DW-1:0] rh [N][N];
  logic [DW-1:0] ch [N][N];
  real acc [N][N];
  logic [127:0] q [$];
  logic [DW-1:0] rq [$];
  logic pe_en = 1'b0;
  logic [AW-1:0] pe_addr = '0;
  int vecs = 0, errs = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic real dec(input logic [7:0] x);
    real m;
    int e, f;
    e = int'(x[6:4]);
    f = int'(x[3:0]);
    m = (e == 0) ? f / 64.0 : ((16 + f) * (1 << e)) / 128.0;
    return x[7] ? -m : m;
  endfunction
  function automatic logic [7:0] enc(input real v);
    real m, best, d;
    logic [6:0] bc;
    m = v < 0 ? -v : v;
    best = 1.0e9;
    bc = '0;
    for (int c = 0; c < 128; c++) begin
      d = dec(8'(c)) - m;
      if (d < 0) d = -d;
      if (d < best) begin
        best = d;
        bc = 7'(c);
      end
    end
    return {(v < 0) && (bc != 0), bc};
  endfunction
  function automatic logic [127:0] pack(input logic b, d, c, r, x, input logic [AW-1:0] a,
                                        input logic [N*DW-1:0] rw, cl);
    return {56'b0, b, d, c, r, x, a, rw, cl};
  endfunction
  task automatic push_job();
    logic [N*DW-1:0] rw, cl;
    logic fe;
    real s;
    for (int t = 1; t <= JOB; t++) begin
      rw = '0;
      cl = '0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = t - 3 - i;
        if (k >= 0 && k < N) begin
          rw[i*DW+:DW] = am[i][k];
          cl[i*DW+:DW] = bm[k][i];
        end
      end
      fe = (t >= 2) && (t <= N + 1);
      q.push_back(pack(t < JOB, t == JOB, t == 1, fe, t == JOB, fe ? AW'(t - 2) : '0, rw, cl));
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0.0;
        for (int k = 0; k < N; k++) s = s + dec(am[i][k]) * dec(bm[k][j]);
        rq.push_back(enc(s));
      end
  endtask
  task automatic cyc();
    logic [127:0] e;
    logic idle;
    @(negedge clk);
    idle = (q.size() == 0);
    e = idle ? '0 : q.pop_front();
    check("trace", pack(busy, done, acc_clr, rd_en, res_capture, rd_addr, row_feed, col_feed), e);
    for (int d = N - 1; d > 0; d--) begin
      rh[d] = rh[d-1];
      ch[d] = ch[d-1];
    end
    for (int i = 0; i < N; i++) begin
      rh[0][i] = row_feed[i*DW+:DW];
      ch[0][i] = col_feed[i*DW+:DW];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc[i][j] = acc_clr ? 0.0 : acc[i][j] + dec(rh[j][i]) * dec(ch[i][j]);
    if (res_capture)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (rq.size() == 0) check("res_extra", 128'(enc(acc[i][j])), 128'h1ff);
          else check("res", 128'(enc(acc[i][j])), 128'(rq.pop_front()));
    if (idle && start && !abort) push_job();
    if (!idle && e[71] && abort) begin
      q.delete();
      rq.delete();
    end
    pe_en = rd_en;
    pe_addr = rd_addr;
    @(posedge clk);
    #1;
    a_rd_data = (N*DW)'($urandom);
    b_rd_data = (N*DW)'($urandom);
    if (pe_en)
      for (int i = 0; i < N; i++) begin
        a_rd_data[i*DW+:DW] = am[i][pe_addr];
        b_rd_data[i*DW+:DW] = bm[pe_addr][i];
      end
  endtask
  task automatic set_basic();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = (k == 0) ? 8'h31 + 8'(i) : 8'h20 + 8'(i * N + k);
        bm[i][k] = 8'h28 + 8'(k * N + i);
      end
  endtask
  task automatic set_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = 8'($urandom);
        bm[i][k] = 8'($urandom);
      end
  endtask
  task automatic run_job();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (JOB + 2) cyc();
  endtask
  initial begin
    for (int d = 0; d < N; d++)
      for (int i = 0; i < N; i++) begin
        rh[d][i] = '0;
        ch[d][i] = '0;
        acc[d][i] = 0.0;
      end
    set_basic();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    run_job();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        am[i][k] = (i == k) ? 8'h30 : 8'h00;
        bm[i][k] = 8'h38;
      end
    run_job();
    set_rand();
    start = 1'b1;
    repeat (3 * JOB) cyc();
    start = 1'b0;
    repeat (JOB + 2) cyc();
    set_rand();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (3) cyc();
    run_job();
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) cyc();
    set_basic();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    #1 rst_n = 1'b0;
    #1 check("rst_async", pack(busy, done, acc_clr, rd_en, res_capture, rd_addr, row_feed, col_feed), '0);
    q.delete();
    rq.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    run_job();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
